dcache_controller: RTL

- Direct-mapped, write-back data cache and controller between the CPU datapath (READ/WRITE/BUSYWAIT from the control unit) and a slow, block-wide data memory.
- Holds the CPU in BUSYWAIT across misses, sequences write-back of dirty blocks and block refills, and serves hits in zero wait cycles.

---
 rtl/dcache_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller with 4-byte blocks between the CPU and a block-wide memory.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t                state;
  logic [31:0]           data_arr [LINES];
  logic [TAG_BITS-1:0]   tag_arr  [LINES];
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [31:0]           fill_data;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  ack_seen;
  logic                  replay;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [31:0]           line_word;
  logic                  req;
  logic                  hit;
  logic                  mem_done;

  assign index    = ADDRESS[INDEX_BITS+1:2];
  assign tag      = ADDRESS[7:INDEX_BITS+2];
  assign req      = READ | WRITE;
  assign hit      = valid[index] && (tag_arr[index] == tag);
  assign mem_done = ack_seen && !MEM_BUSYWAIT;

  // Gating with RESET lets the stall drop the instant reset is asserted, even with a request held.
  assign BUSYWAIT = RESET && ((state != IDLE) || (req && !hit));

  always_comb begin
    line_word = data_arr[index];
    case (ADDRESS[1:0])
      2'd0:    READDATA = line_word[7:0];
      2'd1:    READDATA = line_word[15:8];
      2'd2:    READDATA = line_word[23:16];
      default: READDATA = line_word[31:24];
    endcase
  end

  // Data and tag storage is never cleared; valid bits alone decide what is usable.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (state == FETCH && mem_done)
        fill_data <= MEM_READDATA;
      if (state == UPDATE) begin
        data_arr[miss_index] <= fill_data;
        tag_arr[miss_index]  <= miss_tag;
      end else if (state == IDLE && WRITE && hit) begin
        data_arr[index][{ADDRESS[1:0], 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      miss_index    <= '0;
      miss_tag      <= '0;
      ack_seen      <= 1'b0;
      replay        <= 1'b0;
`ifdef DCACHE_STATS_EN
      HIT_COUNT     <= '0;
      MISS_COUNT    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          replay <= 1'b0;
          if (req && hit) begin
            if (WRITE)
              dirty[index] <= 1'b1;
`ifdef DCACHE_STATS_EN
            if (!replay && HIT_COUNT != 16'hFFFF)
              HIT_COUNT <= HIT_COUNT + 16'd1;
`endif
          end else if (req) begin
            miss_index <= index;
            miss_tag   <= tag;
            ack_seen   <= 1'b0;
`ifdef DCACHE_STATS_EN
            if (MISS_COUNT != 16'hFFFF)
              MISS_COUNT <= MISS_COUNT + 16'd1;
`endif
            if (valid[index] && dirty[index]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_arr[index], index};
              MEM_WRITEDATA <= data_arr[index];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, index};
            end
          end
        end
        WRITEBACK: begin
          if (MEM_BUSYWAIT) begin
            ack_seen <= 1'b1;
          end else if (ack_seen) begin
            state       <= FETCH;
            ack_seen    <= 1'b0;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {miss_tag, miss_index};
          end
        end
        FETCH: begin
          if (MEM_BUSYWAIT) begin
            ack_seen <= 1'b1;
          end else if (ack_seen) begin
            state    <= UPDATE;
            ack_seen <= 1'b0;
            MEM_READ <= 1'b0;
          end
        end
        default: begin
          valid[miss_index] <= 1'b1;
          dirty[miss_index] <= 1'b0;
          replay            <= 1'b1;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule
